// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited in-order requests to
// instruction memory and buffers returned words in a small circular queue for decode.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [63:0] PC_F,
    output logic [31:0] Instr_F,
    output logic        valid_F
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    logic [63:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [63:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_instr [BUF_DEPTH];

    logic          pop;
    logic          accept;
    logic          rsp_keep;
    logic [CW:0]   credits_used;
    logic [CW-1:0] outstanding_after_rsp;
    logic [63:0]   rsp_pc;
    logic          unused_redirect_lsbs;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign valid_F = (count != '0);
    assign PC_F    = valid_F ? buf_pc[head] : 64'h0;
    assign Instr_F = valid_F ? buf_instr[head] : NOP;

    assign pop = valid_F && !stall_F && !redirect;

    // Credits cover both in-flight requests and buffered words, so the buffer can never overflow.
    assign credits_used   = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
    assign imem_req_valid = !rst && !redirect && (credits_used < {1'b0, DEPTH_C});
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_keep              = imem_rsp_valid && (drop_cnt == '0) && !redirect;
    assign outstanding_after_rsp = outstanding - {{(CW-1){1'b0}}, imem_rsp_valid};

    // With nothing left to drop, every in-flight request is live and contiguous below fetch_pc.
    assign rsp_pc = fetch_pc - {{(62-CW){1'b0}}, outstanding, 2'b00};

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= NOP;
            end
        end else if (redirect) begin
            fetch_pc    <= {redirect_pc[63:2], 2'b00};
            outstanding <= outstanding_after_rsp;
            drop_cnt    <= outstanding_after_rsp;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
            outstanding <= outstanding_after_rsp + {{(CW-1){1'b0}}, accept};
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (rsp_keep) begin
                buf_pc[tail]    <= rsp_pc;
                buf_instr[tail] <= imem_rsp_data;
                tail            <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            count <= count + {{(CW-1){1'b0}}, rsp_keep} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rsp_keep && (count == DEPTH_C)));
            assert (drop_cnt <= outstanding);
            assert (outstanding <= DEPTH_C);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cold start, stall, back-pressure, async reset, redirects.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_F;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [63:0] PC_F;
    logic [31:0] Instr_F;
    logic        valid_F;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int mcyc     = 0;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    fetch_unit #(.RESET_PC(64'h1000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .stall_F(stall_F), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .PC_F(PC_F), .Instr_F(Instr_F), .valid_F(valid_F)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory: fixed latency from acceptance, in order, cleared by the shared reset.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: mcyc + mem_lat});
        end
        mcyc++;
    end

    always @(negedge clk) begin
        if (!rst && mq.size() > 0 && mq[0].due <= mcyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rom(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [63:0] pc);
        chk({tag, "_valid"}, {63'h0, valid_F}, 64'h1);
        chk({tag, "_pc"}, PC_F, pc);
        chk({tag, "_instr"}, {32'h0, Instr_F}, {32'h0, 16'hC0DE, pc[15:0]});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {63'h0, valid_F}, 64'h0);
        chk({tag, "_pc"}, PC_F, 64'h0);
        chk({tag, "_instr"}, {32'h0, Instr_F}, 64'h13);
    endtask

    initial begin
        rst = 1'b1; stall_F = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        imem_req_ready = 1'b1; mem_lat = 1;
        cycle(); cycle();
        chk_empty("rst");
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);

        // cold start: request at RESET_PC in the first cycle after release
        cycle(); rst = 1'b0; #1;
        chk("cold_req_valid0", {63'h0, imem_req_valid}, 64'h1);
        chk("cold_req_addr0", imem_req_addr, 64'h1000);
        chk("cold_valid0", {63'h0, valid_F}, 64'h0);
        cycle(); #1;
        chk("cold_req_addr1", imem_req_addr, 64'h1004);
        chk("cold_valid1", {63'h0, valid_F}, 64'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(); #1;
            chk_head("stream", 64'h1000 + 64'(4 * k));
            chk("stream_req_addr", imem_req_addr, 64'h1008 + 64'(4 * k));
        end

        // stall for five cycles with the head at 0x1010
        for (int k = 0; k < 5; k++) begin
            cycle(); stall_F = 1'b1; #1;
            chk_head("stall", 64'h1010);
            chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
        end
        cycle(); stall_F = 1'b0; #1;
        chk_head("unstall0", 64'h1010);
        chk("unstall_req_addr", imem_req_addr, 64'h1018);
        for (int k = 1; k < 4; k++) begin
            cycle(); #1;
            chk_head("unstall", 64'h1010 + 64'(4 * k));
        end

        // back-pressure: request at 0x1028 held for four cycles
        for (int k = 0; k < 4; k++) begin
            cycle(); imem_req_ready = 1'b0; #1;
            chk("bp_req_valid", {63'h0, imem_req_valid}, 64'h1);
            chk("bp_req_addr", imem_req_addr, 64'h1028);
            chk("bp_valid", {63'h0, valid_F}, (k < 2) ? 64'h1 : 64'h0);
        end
        cycle(); imem_req_ready = 1'b1; #1;
        chk("bp_release_addr", imem_req_addr, 64'h1028);
        chk("bp_release_valid", {63'h0, valid_F}, 64'h0);
        cycle(); #1;
        chk("bp_next_addr", imem_req_addr, 64'h102C);
        chk("bp_wait_valid", {63'h0, valid_F}, 64'h0);
        cycle(); #1;
        chk_head("bp_resume0", 64'h1028);
        cycle(); #1;
        chk_head("bp_resume1", 64'h102C);

        // asynchronous reset mid-stream
        rst = 1'b1; #1;
        chk_empty("async_rst");
        chk("async_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cycle(); mem_lat = 3;

        // restart with a 3-cycle memory, redirect while two are in flight
        cycle(); rst = 1'b0; #1;
        chk("restart_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("restart_req_addr", imem_req_addr, 64'h1000);
        cycle(); #1;
        chk("lat3_req_addr1", imem_req_addr, 64'h1004);
        cycle(); redirect = 1'b1; redirect_pc = 64'h2002; #1;
        chk("redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cycle(); redirect = 1'b0; #1;
        chk("redir_t1_valid", {63'h0, valid_F}, 64'h0);
        chk("redir_t1_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("redir_t1_addr", imem_req_addr, 64'h2000);
        cycle(); #1;
        chk("redir_t2_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("redir_t2_addr", imem_req_addr, 64'h2000);
        chk("redir_t2_valid", {63'h0, valid_F}, 64'h0);
        cycle(); #1;
        chk("redir_t3_addr", imem_req_addr, 64'h2004);
        chk("redir_t3_valid", {63'h0, valid_F}, 64'h0);
        cycle(); #1;
        chk("redir_t4_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("redir_t4_valid", {63'h0, valid_F}, 64'h0);
        cycle(); #1;
        chk("redir_t5_valid", {63'h0, valid_F}, 64'h0);
        cycle(); #1;
        chk_head("redir_target", 64'h2000);
        cycle(); #1;
        chk_head("redir_next", 64'h2004);
        cycle(); #1;
        chk("gap0_valid", {63'h0, valid_F}, 64'h0);
        cycle(); #1;
        chk("gap1_valid", {63'h0, valid_F}, 64'h0);

        // redirect, stall and a response all in the same cycle
        cycle(); #1;
        chk_head("combo_pre", 64'h2008);
        redirect = 1'b1; stall_F = 1'b1; redirect_pc = 64'h3000; #1;
        chk("combo_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cycle(); redirect = 1'b0; stall_F = 1'b0; #1;
        chk_empty("combo_t1");
        chk("combo_t1_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("combo_t1_addr", imem_req_addr, 64'h3000);
        for (int k = 0; k < 3; k++) begin
            cycle(); #1;
            chk("combo_wait_valid", {63'h0, valid_F}, 64'h0);
        end
        cycle(); #1;
        chk_head("combo_target", 64'h3000);
        cycle(); #1;
        chk_head("combo_next", 64'h3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
